// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Registers the winning request, holds it until mem_ready or timeout, then pulses ready once.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_dataout,
    output logic              i_ready,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_datain,
    input  logic [3:0]        d_byte_sel,
    output logic [DATA_W-1:0] d_dataout,
    output logic              d_ready,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_byte_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    // Counter value on the last permitted wait cycle; one more miss means timeout.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic {
        G_INSTR,
        G_DATA
    } port_t;

    state_t            state;
    port_t             last_grant;
    port_t             cur_port;
    logic [CNT_W-1:0]  wait_cnt;

    logic              d_req;
    logic              i_req;
    logic              grant_d;
    logic [DATA_W-1:0] resp_data;

    assign d_req   = d_ren | d_wen;
    assign i_req   = i_ren;
    // Data wins when alone, or on a tie when instruction was granted last.
    assign grant_d = d_req & (~i_req | (last_grant == G_INSTR));
    // Writes and timeouts return zero data.
    assign resp_data = (mem_ready && mem_ren) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            last_grant   <= G_INSTR;
            cur_port     <= G_INSTR;
            wait_cnt     <= '0;
            i_dataout    <= '0;
            i_ready      <= 1'b0;
            d_dataout    <= '0;
            d_ready      <= 1'b0;
            mem_ren      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_byte_sel <= 4'b0000;
            bus_err      <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            bus_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (d_req || i_req) begin
                        state    <= S_BUSY;
                        wait_cnt <= '0;
                        if (grant_d) begin
                            cur_port     <= G_DATA;
                            last_grant   <= G_DATA;
                            mem_wen      <= d_wen;
                            mem_ren      <= ~d_wen;
                            mem_addr     <= d_addr;
                            mem_wdata    <= d_datain;
                            mem_byte_sel <= d_byte_sel;
                        end else begin
                            cur_port     <= G_INSTR;
                            last_grant   <= G_INSTR;
                            mem_wen      <= 1'b0;
                            mem_ren      <= 1'b1;
                            mem_addr     <= i_addr;
                            mem_wdata    <= '0;
                            mem_byte_sel <= 4'b1111;
                        end
                    end
                end

                S_BUSY: begin
                    // mem_ready is checked first so it wins over a simultaneous timeout.
                    if (mem_ready || (wait_cnt == WAIT_LAST)) begin
                        state   <= S_DONE;
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        bus_err <= ~mem_ready;
                        if (cur_port == G_DATA) begin
                            d_ready   <= 1'b1;
                            d_dataout <= resp_data;
                        end else begin
                            i_ready   <= 1'b1;
                            i_dataout <= resp_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_ren;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_dataout;
    logic          i_ready;
    logic          d_ren;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_datain;
    logic [3:0]    d_byte_sel;
    logic [DW-1:0] d_dataout;
    logic          d_ready;
    logic          mem_ren;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_byte_sel;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .i_ren(i_ren), .i_addr(i_addr), .i_dataout(i_dataout), .i_ready(i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_datain(d_datain),
        .d_byte_sel(d_byte_sel), .d_dataout(d_dataout), .d_ready(d_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_sel(mem_byte_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: one outstanding transaction record plus expected outputs for the current cycle.
    bit            m_act;      // transaction strobed on the memory port this cycle
    bit            m_rdy;      // this cycle is the completion-pulse cycle
    bit            m_is_d;
    bit            m_wr;
    bit            m_last_d;
    bit            m_fresh;    // previous edge was a reset
    int            m_waited;
    int            m_wplan;    // bench memory latency plan for the current transaction

    logic          e_ren, e_wen, e_ir, e_dr, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_idata, e_ddata;
    logic [3:0]    e_bsel;

    bit i_pend, d_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit          dreq;
        logic [31:0] data;
        if (reset) begin
            {e_ren, e_wen, e_ir, e_dr, e_err} = '0;
            e_addr = '0; e_wdata = '0; e_idata = '0; e_ddata = '0; e_bsel = '0;
            m_act = 0; m_rdy = 0; m_last_d = 0; m_waited = 0; m_fresh = 1;
            return;
        end
        m_fresh = 0;
        e_ir = 0; e_dr = 0; e_err = 0;
        if (m_rdy) begin
            m_rdy = 0;
        end else if (m_act) begin
            if (mem_ready || (m_waited + 1 >= int'(MW))) begin
                data  = (mem_ready && !m_wr) ? mem_rdata : 32'h0;
                e_err = !mem_ready;
                e_ren = 0; e_wen = 0;
                if (m_is_d) begin e_dr = 1; e_ddata = data; end
                else        begin e_ir = 1; e_idata = data; end
                m_act = 0; m_rdy = 1; m_waited = 0;
            end else begin
                m_waited++;
            end
        end else begin
            dreq = d_ren | d_wen;
            if (dreq && (!i_ren || !m_last_d)) begin
                m_is_d = 1; m_last_d = 1; m_wr = d_wen;
                e_wen = d_wen; e_ren = !d_wen;
                e_addr = d_addr; e_wdata = d_datain; e_bsel = d_byte_sel;
                m_act = 1; m_waited = 0; m_wplan = int'($urandom_range(0, MW));
            end else if (i_ren) begin
                m_is_d = 0; m_last_d = 0; m_wr = 0;
                e_ren = 1; e_wen = 0; e_addr = i_addr; e_bsel = 4'hF;
                m_act = 1; m_waited = 0; m_wplan = int'($urandom_range(0, MW));
            end
        end
    endtask

    task automatic compare();
        check("mem_ren", 32'(mem_ren), 32'(e_ren));
        check("mem_wen", 32'(mem_wen), 32'(e_wen));
        check("i_ready", 32'(i_ready), 32'(e_ir));
        check("d_ready", 32'(d_ready), 32'(e_dr));
        check("bus_err", 32'(bus_err), 32'(e_err));
        if (e_ren || e_wen || m_fresh) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_byte_sel", 32'(mem_byte_sel), 32'(e_bsel));
        end
        if (e_wen || m_fresh) check("mem_wdata", mem_wdata, e_wdata);
        if (e_ir || m_fresh)  check("i_dataout", i_dataout, e_idata);
        if (e_dr || m_fresh)  check("d_dataout", d_dataout, e_ddata);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic clear_inputs();
        i_ren = 0; i_addr = '0; d_ren = 0; d_wen = 0; d_addr = '0;
        d_datain = '0; d_byte_sel = '0; mem_rdata = '0; mem_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic rand_stim();
        int unsigned kind;
        reset = ($urandom_range(0, 399) == 0);
        if (e_ir)         i_pend = ($urandom_range(0, 3) == 0);
        else if (!i_pend) i_pend = ($urandom_range(0, 2) == 0);
        if (i_pend && (!i_ren || $urandom_range(0, 3) == 0)) i_addr = $urandom;
        i_ren = i_pend;

        if (e_dr)         d_pend = ($urandom_range(0, 3) == 0);
        else if (!d_pend) d_pend = ($urandom_range(0, 2) == 0);
        if (d_pend && (!(d_ren || d_wen) || $urandom_range(0, 3) == 0)) begin
            kind       = $urandom_range(0, 2);
            d_ren      = (kind != 1);
            d_wen      = (kind != 0);
            d_addr     = $urandom;
            d_datain   = $urandom;
            d_byte_sel = 4'($urandom);
        end else if (!d_pend) begin
            d_ren = 0; d_wen = 0;
        end

        mem_rdata = $urandom;
        mem_ready = m_act && (m_waited == m_wplan);
    endtask

    initial begin
        clear_inputs();
        i_pend = 0; d_pend = 0;
        m_act = 0; m_rdy = 0; m_last_d = 0; m_fresh = 0; m_waited = 0; m_wplan = 0;

        // Reset state and single instruction read
        do_reset();
        check("lit_reset_mem_ren", 32'(mem_ren), 32'd0);
        check("lit_reset_i_ready", 32'(i_ready), 32'd0);
        i_ren = 1; i_addr = 32'h100;
        cycle();
        check("lit_ifetch_ren", 32'(mem_ren), 32'd1);
        check("lit_ifetch_addr", mem_addr, 32'h100);
        check("lit_ifetch_bsel", 32'(mem_byte_sel), 32'hF);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        cycle();
        check("lit_ifetch_ready", 32'(i_ready), 32'd1);
        check("lit_ifetch_data", i_dataout, 32'hDEADBEEF);
        check("lit_ifetch_dready", 32'(d_ready), 32'd0);
        i_ren = 0; mem_ready = 0;
        cycle();
        check("lit_ifetch_ready_off", 32'(i_ready), 32'd0);

        // Data write with three wait cycles
        d_wen = 1; d_addr = 32'h2000; d_datain = 32'h12345678; d_byte_sel = 4'b0011;
        cycle();
        for (int k = 0; k < 3; k++) begin
            check("lit_wr_wen", 32'(mem_wen), 32'd1);
            check("lit_wr_data", mem_wdata, 32'h12345678);
            cycle();
        end
        check("lit_wr_wen4", 32'(mem_wen), 32'd1);
        check("lit_wr_bsel", 32'(mem_byte_sel), 32'h3);
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        cycle();
        check("lit_wr_dready", 32'(d_ready), 32'd1);
        check("lit_wr_dout", d_dataout, 32'd0);
        check("lit_wr_wen_off", 32'(mem_wen), 32'd0);
        clear_inputs();
        cycle();

        // Timeout: no mem_ready for MAX_WAIT cycles
        d_ren = 1; d_addr = 32'h40;
        cycle();
        repeat (3) cycle();
        check("lit_to_ren_held", 32'(mem_ren), 32'd1);
        cycle();
        check("lit_to_ren_off", 32'(mem_ren), 32'd0);
        check("lit_to_dready", 32'(d_ready), 32'd1);
        check("lit_to_buserr", 32'(bus_err), 32'd1);
        check("lit_to_dout", d_dataout, 32'd0);
        d_ren = 0;
        cycle();
        check("lit_to_buserr_off", 32'(bus_err), 32'd0);

        // mem_ready exactly on the timeout cycle wins
        d_ren = 1; d_addr = 32'h44;
        cycle();
        repeat (3) cycle();
        mem_ready = 1; mem_rdata = 32'h5A5A1234;
        cycle();
        check("lit_edge_dready", 32'(d_ready), 32'd1);
        check("lit_edge_buserr", 32'(bus_err), 32'd0);
        check("lit_edge_data", d_dataout, 32'h5A5A1234);
        clear_inputs();
        cycle();

        // Reset mid-access, request still held afterwards
        i_ren = 1; i_addr = 32'h300;
        cycle();
        cycle();
        reset = 1; mem_ready = 1; mem_rdata = 32'h1111;
        cycle();
        reset = 0; mem_ready = 0;
        check("lit_rst_ren", 32'(mem_ren), 32'd0);
        check("lit_rst_iready", 32'(i_ready), 32'd0);
        cycle();
        check("lit_rst_regrant", 32'(mem_ren), 32'd1);
        mem_ready = 1;
        cycle();
        i_ren = 0; mem_ready = 0;
        cycle();

        // Request held past ready starts a fresh fetch
        i_ren = 1; i_addr = 32'h500;
        cycle();
        mem_ready = 1; mem_rdata = 32'h77;
        cycle();
        check("lit_hold_iready", 32'(i_ready), 32'd1);
        mem_ready = 0;
        cycle();
        check("lit_hold_idle", 32'(mem_ren), 32'd0);
        cycle();
        check("lit_hold_regrant", 32'(mem_ren), 32'd1);
        mem_ready = 1;
        cycle();
        clear_inputs();
        cycle();

        // Simultaneous requests after reset alternate D,I,D,I
        do_reset();
        i_ren = 1; i_addr = 32'hA00; d_ren = 1; d_addr = 32'hB00; d_byte_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            cycle();
            mem_ready = 1; mem_rdata = 32'(k);
            cycle();
            check("lit_rr_dready", 32'(d_ready), 32'((k % 2) == 0));
            check("lit_rr_iready", 32'(i_ready), 32'((k % 2) == 1));
            mem_ready = 0;
            cycle();
        end
        clear_inputs();
        cycle();

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rand_stim();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
